// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: 1 s tick prescaler, run/pause/lap/clear FSM,
// BCD MM:SS counter with lap-freeze display registers.
module stopwatch_ctrl #(
  parameter int DIV_COUNT = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       tick_o,
  output logic       running,
  output logic       lap_active,
  output logic       wrap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
);

  localparam int PW = $clog2(DIV_COUNT);
  localparam logic [PW-1:0] LAST = PW'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_so, r_st, r_mo, r_mt;
  logic [3:0]    w_so, w_st, w_mo, w_mt;
  logic          w_count;
  logic          w_tick;
  logic          w_zero;
  logic          w_wrap;
  logic          w_hold;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state decode; clear outranks start_stop in PAUSE
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_stop) w_state_n = S_RUN;
      end
      S_RUN: begin
        if (start_stop) w_state_n = S_PAUSE;
        else if (lap)   w_state_n = S_LAP;
      end
      S_LAP: begin
        if (start_stop) w_state_n = S_PAUSE;
        else if (lap)   w_state_n = S_RUN;
      end
      S_PAUSE: begin
        if (clear)           w_state_n = S_IDLE;
        else if (start_stop) w_state_n = S_RUN;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_count = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick  = w_count && (r_presc == LAST);
  assign w_zero  = (w_state_n == S_IDLE);
  assign w_hold  = (r_state == S_LAP) && (w_state_n == S_LAP);

  // Prescaler: counts while running, holds in PAUSE, zero in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_presc <= '0;
    else if (w_zero)  r_presc <= '0;
    else if (w_tick)  r_presc <= '0;
    else if (w_count) r_presc <= r_presc + PW'(1);
  end

  // Next live time: BCD ripple carry on tick, wrap after 59:59
  always_comb begin
    w_so   = r_so;
    w_st   = r_st;
    w_mo   = r_mo;
    w_mt   = r_mt;
    w_wrap = 1'b0;
    if (w_zero) begin
      w_so = 4'd0;
      w_st = 4'd0;
      w_mo = 4'd0;
      w_mt = 4'd0;
    end else if (w_tick) begin
      if (r_so != 4'd9) begin
        w_so = r_so + 4'd1;
      end else begin
        w_so = 4'd0;
        if (r_st != 4'd5) begin
          w_st = r_st + 4'd1;
        end else begin
          w_st = 4'd0;
          if (r_mo != 4'd9) begin
            w_mo = r_mo + 4'd1;
          end else begin
            w_mo = 4'd0;
            if (r_mt != 4'd5) begin
              w_mt = r_mt + 4'd1;
            end else begin
              w_mt   = 4'd0;
              w_wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  // Live time registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_so <= 4'd0;
      r_st <= 4'd0;
      r_mo <= 4'd0;
      r_mt <= 4'd0;
    end else begin
      r_so <= w_so;
      r_st <= w_st;
      r_mo <= w_mo;
      r_mt <= w_mt;
    end
  end

  // Status outputs, registered alongside the new state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_o     <= 1'b0;
      wrap       <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      tick_o     <= w_tick;
      wrap       <= w_wrap;
      running    <= (w_state_n == S_RUN) || (w_state_n == S_LAP);
      lap_active <= (w_state_n == S_LAP);
    end
  end

  // Display: follows live time, frozen while staying in LAP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (!w_hold) begin
      sec_ones <= w_so;
      sec_tens <= w_st;
      min_ones <= w_mo;
      min_tens <= w_mt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table plus
// sequences for ticks, lap freeze, wrap and async reset.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       tick_o;
  logic       running;
  logic       lap_active;
  logic       wrap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [15:0] disp;

  int errs   = 0;
  int checks = 0;

  stopwatch_ctrl #(.DIV_COUNT(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .tick_o    (tick_o),
    .running   (running),
    .lap_active(lap_active),
    .wrap      (wrap),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens)
  );

  always #5 clk = ~clk;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  typedef struct {
    logic        s;
    logic        l;
    logic        c;
    logic        tk;
    logic        run;
    logic        la;
    logic        wr;
    logic [15:0] t;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic s, logic l, logic c, logic tk,
                             logic run, logic la, logic wr,
                             logic [15:0] t);
    vec_t r;
    r.s = s; r.l = l; r.c = c; r.tk = tk;
    r.run = run; r.la = la; r.wr = wr; r.t = t;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic l, input logic c);
    start_stop = s;
    lap        = l;
    clear      = c;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic do_reset();
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " tick"}, 32'(tick_o), 0);
    chk({nm, " run"},  32'(running), 0);
    chk({nm, " lap"},  32'(lap_active), 0);
    chk({nm, " wrap"}, 32'(wrap), 0);
    chk({nm, " time"}, 32'(disp), 0);
  endtask

  initial begin
    int nwrap;

    vt.push_back(v(1,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 1,1,0,0, 16'h0001));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0001));
    vt.push_back(v(1,0,0, 0,0,0,0, 16'h0001));
    vt.push_back(v(0,0,0, 0,0,0,0, 16'h0001));
    vt.push_back(v(0,1,0, 0,0,0,0, 16'h0001));
    vt.push_back(v(0,0,0, 0,0,0,0, 16'h0001));
    vt.push_back(v(1,0,0, 0,1,0,0, 16'h0001));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0001));
    vt.push_back(v(0,0,0, 1,1,0,0, 16'h0002));
    vt.push_back(v(0,1,0, 0,1,1,0, 16'h0002));
    vt.push_back(v(0,0,0, 0,1,1,0, 16'h0002));
    vt.push_back(v(0,0,0, 0,1,1,0, 16'h0002));
    vt.push_back(v(0,0,0, 1,1,1,0, 16'h0002));
    vt.push_back(v(0,1,0, 0,1,0,0, 16'h0003));
    vt.push_back(v(0,0,1, 0,1,0,0, 16'h0003));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0003));
    vt.push_back(v(1,0,0, 1,0,0,0, 16'h0004));
    vt.push_back(v(0,0,0, 0,0,0,0, 16'h0004));
    vt.push_back(v(1,0,1, 0,0,0,0, 16'h0000));
    vt.push_back(v(0,1,0, 0,0,0,0, 16'h0000));
    vt.push_back(v(0,0,1, 0,0,0,0, 16'h0000));
    vt.push_back(v(1,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 0,1,0,0, 16'h0000));
    vt.push_back(v(0,0,0, 1,1,0,0, 16'h0001));

    do_reset();
    chk_zero("reset");

    foreach (vt[i]) begin
      step(vt[i].s, vt[i].l, vt[i].c);
      chk($sformatf("vec%0d tick", i), 32'(tick_o), 32'(vt[i].tk));
      chk($sformatf("vec%0d run", i), 32'(running), 32'(vt[i].run));
      chk($sformatf("vec%0d lap", i), 32'(lap_active), 32'(vt[i].la));
      chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vt[i].wr));
      chk($sformatf("vec%0d time", i), 32'(disp), 32'(vt[i].t));
    end

    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("ticks e%0d", e), 32'(tick_o),
          32'((e % DIV) == 0));
    end
    chk("ten s time", 32'(disp), 32'h0010);
    chk("ten s run", 32'(running), 1);

    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) step(1'b0, 1'b0, 1'b0);
    chk("pre lap time", 32'(disp), 32'h0005);
    step(1'b0, 1'b1, 1'b0);
    chk("lap enter la", 32'(lap_active), 1);
    chk("lap enter time", 32'(disp), 32'h0005);
    for (int e = 22; e <= 61; e++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("frozen e%0d", e), 32'(disp), 32'h0005);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("lap release la", 32'(lap_active), 0);
    chk("lap release time", 32'(disp), 32'h0015);
    step(1'b0, 1'b1, 1'b0);
    chk("lap again la", 32'(lap_active), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("lap stop tick", 32'(tick_o), 1);
    chk("lap stop run", 32'(running), 0);
    chk("lap stop la", 32'(lap_active), 0);
    chk("lap stop time", 32'(disp), 32'h0016);

    do_reset();
    nwrap = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 3600 * DIV; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (e < 3600 * DIV && wrap) nwrap++;
      if (e == 3599 * DIV) chk("at 59:59", 32'(disp), 32'h5959);
    end
    chk("early wrap", 32'(nwrap), 0);
    chk("wrap time", 32'(disp), 32'h0000);
    chk("wrap pulse", 32'(wrap), 1);
    chk("wrap tick", 32'(tick_o), 1);
    chk("wrap run", 32'(running), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap one cyc", 32'(wrap), 0);
    chk("wrap still run", 32'(running), 1);

    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 754 * DIV; e++) step(1'b0, 1'b0, 1'b0);
    chk("at 12:34", 32'(disp), 32'h1234);
    step(1'b0, 1'b1, 1'b0);
    chk("12:34 lap", 32'(lap_active), 1);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk_zero("post rst");
    step(1'b1, 1'b0, 1'b0);
    chk("post rst start", 32'(running), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
